conv1d_agu_multi: RTL
=====================

# conv1d_agu_multi

Parametrised address generator and sequencer for the single-MAC Conv1D datapath. It adds multiple filters, arbitrary stride, a start/busy/done handshake, a stall input and optional zero padding. For every filter and every output position it clears the accumulator, streams KERNEL_SIZE weight/input address pairs, then flags the result valid and commands the write-back. It sits between the weight/input buffers and the output buffer, driven by the top-level controller.

## Interface
- KERNEL_SIZE, 3, taps per filter (≥1)
- STRIDE, 1, window step in input samples (≥1)
- INPUT_SIZE, 27, input samples per channel (≥KERNEL_SIZE)
- NUM_FILTERS, 4, filters processed back to back (≥1)
- W_ADDR_BITS, 4, weight address width (holds NUM_FILTERS*KERNEL_SIZE-1)
- X_ADDR_BITS, 5, input address width (holds INPUT_SIZE-1)
- O_ADDR_BITS, 7, output address width (holds NUM_FILTERS*OUT_SIZE-1)
- Derived OUT_SIZE: (INPUT_SIZE-KERNEL_SIZE)/STRIDE+1, integer division; padded form under Configuration.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a full pass; sampled only in IDLE
- hold  in  1  stall: freezes state, counters and all outputs
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last write
- w_address  out  W_ADDR_BITS  weight buffer read address
- x_address  out  X_ADDR_BITS  input buffer read address
- x_pad  out  1  current tap is padding; MAC must add zero
- out_address  out  O_ADDR_BITS  output buffer write address
- clear  out  1  accumulator clear
- valid  out  1  accumulator result valid
- write  out  1  output buffer write enable

## Operation
- States: IDLE, CLEAR, MAC, VALID, WRITE, DONE.
- Counters: filter f (0..NUM_FILTERS-1, outer), output position o (0..OUT_SIZE-1, inner), tap t (0..KERNEL_SIZE-1).
- IDLE: start=1 → CLEAR with f=o=t=0; otherwise stay.
- CLEAR: clear=1; → MAC.
- MAC: w_address=f*KERNEL_SIZE+t, x_address=o*STRIDE+t; t increments; after t=KERNEL_SIZE-1 → VALID.
- VALID: valid=1, out_address=f*OUT_SIZE+o; → WRITE.
- WRITE: write=1, out_address held; t←0; o increments, wrapping to 0 with f increment; → CLEAR, or → DONE after last (f,o).
- DONE: done=1; → IDLE. busy low in IDLE only.
- Address arithmetic uses internal widths ≥ max(X_ADDR_BITS, W_ADDR_BITS, O_ADDR_BITS)+1, truncated at the port; parameters must keep values in range. Sequence never produces an out-of-range address.
- Outputs not named in the current state are 0, except addresses, which hold their last value.

## Timing
- All outputs registered; they reflect the state entered on that clock edge.
- Reset (async, any state): state IDLE, counters 0, all outputs 0 (addresses 0, x_pad 0). Reset mid-pass aborts; no done.
- start accepted at edge N → clear=1 and busy=1 after edge N+1.
- Per output: KERNEL_SIZE+3 cycles (CLEAR, K×MAC, VALID, WRITE).
- Pass length: NUM_FILTERS*OUT_SIZE*(KERNEL_SIZE+3) cycles from first clear to last write; done one cycle after the last write.
- hold=1: no state/counter/output change that edge, including the done pulse; hold in IDLE blocks start. start while busy is ignored.
- start and hold both high in IDLE: hold wins; start must be reasserted.

## Configuration
- CONV1D_AGU_ZERO_PAD_EN defined: P=(KERNEL_SIZE-1)/2; OUT_SIZE=(INPUT_SIZE+2P-KERNEL_SIZE)/STRIDE+1; input index i=o*STRIDE+t-P computed signed; if i<0 or i≥INPUT_SIZE then x_pad=1, x_address=0, else x_pad=0, x_address=i. x_pad valid only in MAC, 0 elsewhere.
- Undefined: no padding, x_pad tied 0, formulas as in Operation.

## Test plan
- Defaults, start one cycle → OUT_SIZE=25, 100 writes, first clear 1 cycle after start, done exactly 600 cycles after first clear; out_address 0..99 in order.
- Defaults, filter 2 position 4 → w_address 6,7,8; x_address 4,5,6; out_address 54 during VALID/WRITE.
- STRIDE=2, INPUT_SIZE=9, NUM_FILTERS=1 → 4 writes; last window x_address 6,7,8.
- hold high 5 cycles mid-MAC → all outputs frozen, total pass stretched by 5 cycles, no address skipped or repeated.
- rst asserted mid-VALID → outputs 0 immediately, IDLE, no done; next start restarts from f=o=0.
- CONV1D_AGU_ZERO_PAD_EN, K=3, IN=27 → OUT_SIZE=27; position 0 tap 0 x_pad=1, x_address=0; position 26 tap 2 x_pad=1.

Source files
------------

// File: rtl/conv1d_agu_multi.sv
// conv1d_agu_multi: multi-filter strided Conv1D address sequencer; define CONV1D_AGU_ZERO_PAD_EN for zero padding
module conv1d_agu_multi #(
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int INPUT_SIZE  = 27,
    parameter int NUM_FILTERS = 4,
    parameter int W_ADDR_BITS = 4,
    parameter int X_ADDR_BITS = 5,
    parameter int O_ADDR_BITS = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   hold,
    output logic                   busy,
    output logic                   done,
    output logic [W_ADDR_BITS-1:0] w_address,
    output logic [X_ADDR_BITS-1:0] x_address,
    output logic                   x_pad,
    output logic [O_ADDR_BITS-1:0] out_address,
    output logic                   clear,
    output logic                   valid,
    output logic                   write
);
`ifdef CONV1D_AGU_ZERO_PAD_EN
    localparam int PAD = (KERNEL_SIZE - 1) / 2;
`else
    localparam int PAD = 0;
`endif
    localparam int OUT_SIZE = (INPUT_SIZE + 2 * PAD - KERNEL_SIZE) / STRIDE + 1;
    localparam int MW = W_ADDR_BITS > X_ADDR_BITS ? (W_ADDR_BITS > O_ADDR_BITS ? W_ADDR_BITS : O_ADDR_BITS)
                                                  : (X_ADDR_BITS > O_ADDR_BITS ? X_ADDR_BITS : O_ADDR_BITS);
    localparam int CW = MW + 1;
    localparam logic [CW-1:0] T_LAST = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] O_LAST = CW'(OUT_SIZE - 1);
    localparam logic [CW-1:0] F_LAST = CW'(NUM_FILTERS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, MAC, VALID, WRITE, DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_f, r_o, r_t;
    logic          w_o_last, w_last;

    assign w_o_last = r_o == O_LAST;
    assign w_last   = w_o_last && r_f == F_LAST;

    function automatic int idx(int o, int t);
        return o * STRIDE + t - PAD;
    endfunction

    function automatic logic in_pad(int i);
        return (PAD != 0) && (i < 0 || i >= INPUT_SIZE);
    endfunction

    function automatic logic [X_ADDR_BITS-1:0] x_addr(int i);
        return in_pad(i) ? '0 : i[X_ADDR_BITS-1:0];
    endfunction

    function automatic logic [W_ADDR_BITS-1:0] w_addr(int f, int t);
        int v = f * KERNEL_SIZE + t;
        return v[W_ADDR_BITS-1:0];
    endfunction

    function automatic logic [O_ADDR_BITS-1:0] o_addr(int f, int o);
        int v = f * OUT_SIZE + o;
        return v[O_ADDR_BITS-1:0];
    endfunction

    // sequencer FSM; every output is registered for the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_f         <= '0;
            r_o         <= '0;
            r_t         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            w_address   <= '0;
            x_address   <= '0;
            x_pad       <= 1'b0;
            out_address <= '0;
            clear       <= 1'b0;
            valid       <= 1'b0;
            write       <= 1'b0;
        end else if (!hold) begin
            clear <= 1'b0;
            valid <= 1'b0;
            write <= 1'b0;
            done  <= 1'b0;
            x_pad <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= CLEAR;
                    r_f     <= '0;
                    r_o     <= '0;
                    r_t     <= '0;
                    busy    <= 1'b1;
                    clear   <= 1'b1;
                end
                CLEAR: begin
                    r_state   <= MAC;
                    r_t       <= '0;
                    w_address <= w_addr(int'(r_f), 0);
                    x_address <= x_addr(idx(int'(r_o), 0));
                    x_pad     <= in_pad(idx(int'(r_o), 0));
                end
                MAC: if (r_t == T_LAST) begin
                    r_state     <= VALID;
                    valid       <= 1'b1;
                    out_address <= o_addr(int'(r_f), int'(r_o));
                end else begin
                    r_t       <= r_t + 1'b1;
                    w_address <= w_addr(int'(r_f), int'(r_t) + 1);
                    x_address <= x_addr(idx(int'(r_o), int'(r_t) + 1));
                    x_pad     <= in_pad(idx(int'(r_o), int'(r_t) + 1));
                end
                VALID: begin
                    r_state <= WRITE;
                    write   <= 1'b1;
                end
                WRITE: begin
                    r_state <= w_last ? DONE : CLEAR;
                    r_t     <= '0;
                    r_o     <= w_o_last ? '0 : r_o + 1'b1;
                    r_f     <= w_o_last ? r_f + 1'b1 : r_f;
                    clear   <= !w_last;
                    done    <= w_last;
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
